// File: rtl/ram_responder.sv
// RAM model on the far side of the memory_control RAM port: programmable
// access latency, request restart on arbiter switch, and illegal-request reporting.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned WORDS = 16384
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int unsigned CW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam int unsigned AW = (WORDS < 2) ? 1 : $clog2(WORDS);
  localparam logic [32:0] BYTES = 33'(WORDS) << 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  ramstate_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  word_t         addr_q, addr_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  word_t         load_d;
  logic          fresh;
  logic          req_c, illegal_c, same_c, mem_we_c;

  word_t mem [WORDS] = '{default: '0};

  assign req_c     = ramREN | ramWEN;
  assign illegal_c = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) | ({1'b0, ramaddr} >= BYTES);
  assign same_c    = (ramaddr == addr_q) && (ramREN == ren_q) && (ramWEN == wen_q);
  // A write only lands if the requester is still presenting it when ACCESS closes.
  assign mem_we_c  = (state_q == ACCESS) & wen_q & ramWEN & (ramaddr == addr_q);
  assign ramstate  = state_q;

  // Next-state: every state except a stable BUSY treats the inputs as a new request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    fresh   = 1'b0;
    load_d  = '0;

    case (state_q)
      BUSY: begin
        if (!req_c) begin
          state_d = FREE;
        end else if (!same_c) begin
          fresh = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: fresh = 1'b1;
    endcase

    if (fresh) begin
      cnt_d = '0;
      if (!req_c) begin
        state_d = FREE;
      end else if (illegal_c) begin
        state_d = ERROR;
      end else begin
        addr_d  = ramaddr;
        ren_d   = ramREN;
        wen_d   = ramWEN;
        state_d = (LAT == 0) ? ACCESS : BUSY;
      end
    end

    if ((state_d == ACCESS) && ren_d) begin
      load_d = mem[addr_d[AW+1:2]];
    end
  end

  // Control and read-data registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FREE;
      cnt_q   <= '0;
      addr_q  <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      ramload <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      ramload <= load_d;
    end
  end

  // Word array; contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we_c) begin
      mem[addr_q[AW+1:2]] <= ramstore;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: one instance with LAT=2, one with LAT=0.
module tb_ram_responder;
  import cpu_types_pkg::*;

  typedef struct {
    int        d;
    ramstate_t st;
    word_t     ld;
    string     tag;
  } exp_t;

  logic      CLK;
  logic      nRST;
  logic      ren0, wen0, ren1, wen1;
  word_t     addr0, store0, addr1, store1;
  word_t     load0, load1;
  ramstate_t rs0, rs1;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ram_responder #(.LAT(2), .WORDS(16384)) u_lat2 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren0), .ramWEN(wen0),
    .ramaddr(addr0), .ramstore(store0), .ramload(load0), .ramstate(rs0)
  );

  ram_responder #(.LAT(0), .WORDS(16384)) u_lat0 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren1), .ramWEN(wen1),
    .ramaddr(addr1), .ramstore(store1), .ramload(load1), .ramstate(rs1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare DUT outputs against queued expectations mid-cycle.
  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.d == 0) begin
        check({e.tag, ".state"}, 32'(rs0), 32'(e.st));
        check({e.tag, ".load"}, load0, e.ld);
      end else begin
        check({e.tag, ".state"}, 32'(rs1), 32'(e.st));
        check({e.tag, ".load"}, load1, e.ld);
      end
    end
  end

  task automatic expect_now(input int d, input ramstate_t st, input word_t ld, input string tag);
    exp_t e;
    e.d = d; e.st = st; e.ld = ld; e.tag = tag;
    sb.push_back(e);
  endtask

  // One cycle: drive inputs just after the edge, queue what this cycle must show.
  task automatic step(input int d, input logic ren, input logic wen, input word_t addr,
                      input word_t store, input ramstate_t st, input word_t ld, input string tag);
    @(posedge CLK);
    #1;
    if (d == 0) begin
      ren0 = ren; wen0 = wen; addr0 = addr; store0 = store;
    end else begin
      ren1 = ren; wen1 = wen; addr1 = addr; store1 = store;
    end
    expect_now(d, st, ld, tag);
  endtask

  // Full LAT=2 transaction from FREE, request held through ACCESS, then released.
  task automatic xact(input logic ren, input logic wen, input word_t addr, input word_t store,
                      input word_t ld, input string tag);
    step(0, ren, wen, addr, store, FREE, 32'h0, {tag, "_c0"});
    step(0, ren, wen, addr, store, BUSY, 32'h0, {tag, "_c1"});
    step(0, ren, wen, addr, store, BUSY, 32'h0, {tag, "_c2"});
    step(0, ren, wen, addr, store, ACCESS, ld, {tag, "_acc"});
    step(0, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0, {tag, "_rehold"});
    step(0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, {tag, "_idle"});
  endtask

  initial begin
    word_t wv [4];
    nRST = 1'b0;
    ren0 = 1'b0; wen0 = 1'b0; addr0 = '0; store0 = '0;
    ren1 = 1'b0; wen1 = 1'b0; addr1 = '0; store1 = '0;
    for (int i = 0; i < 4; i++) wv[i] = 32'hA5000000 | word_t'(i * 32'h111);

    // Outputs idle while reset is held.
    @(posedge CLK); #1;
    expect_now(0, FREE, 32'h0, "rst0");
    expect_now(1, FREE, 32'h0, "rst1");
    @(posedge CLK); #1;
    nRST = 1'b1;
    expect_now(0, FREE, 32'h0, "rel0");
    expect_now(1, FREE, 32'h0, "rel1");

    // Reset in the middle of a write discards it.
    step(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, FREE, 32'h0, "rstw_c0");
    step(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, BUSY, 32'h0, "rstw_c1");
    @(posedge CLK); #1;
    nRST = 1'b0;
    ren0 = 1'b0; wen0 = 1'b0; addr0 = '0; store0 = '0;
    expect_now(0, FREE, 32'h0, "rstw_async");
    @(posedge CLK); #1;
    expect_now(0, FREE, 32'h0, "rstw_hold");
    @(posedge CLK); #1;
    nRST = 1'b1;
    expect_now(0, FREE, 32'h0, "rstw_rel");
    xact(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, "rd40");

    // Write then read back.
    xact(1'b0, 1'b1, 32'h100, 32'hCAFEF00D, 32'h0, "wr100");
    xact(1'b1, 1'b0, 32'h100, 32'h0, 32'hCAFEF00D, "rd100");
    xact(1'b0, 1'b1, 32'h200, 32'h12345678, 32'h0, "wr200");

    // Arbiter switches from I-read of 0x0 to D-read of 0x200 in the first BUSY cycle.
    step(0, 1'b1, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "sw_c0");
    step(0, 1'b1, 1'b0, 32'h200, 32'h0, BUSY, 32'h0, "sw_switch");
    step(0, 1'b1, 1'b0, 32'h200, 32'h0, BUSY, 32'h0, "sw_busy0");
    step(0, 1'b1, 1'b0, 32'h200, 32'h0, BUSY, 32'h0, "sw_busy1");
    step(0, 1'b1, 1'b0, 32'h200, 32'h0, ACCESS, 32'h12345678, "sw_acc");
    step(0, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0, "sw_rehold");
    step(0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "sw_idle");

    // Illegal requests report ERROR and never touch the array.
    step(0, 1'b1, 1'b1, 32'h100, 32'hBAD0BAD0, FREE, 32'h0, "ill_both");
    step(0, 1'b0, 1'b1, 32'h103, 32'hBAD0BAD0, ERROR, 32'h0, "ill_unal");
    step(0, 1'b0, 1'b1, 32'h10000, 32'hBAD0BAD0, ERROR, 32'h0, "ill_range");
    step(0, 1'b1, 1'b0, 32'h100, 32'h0, ERROR, 32'h0, "ill_fix");
    step(0, 1'b1, 1'b0, 32'h100, 32'h0, BUSY, 32'h0, "ill_busy0");
    step(0, 1'b1, 1'b0, 32'h100, 32'h0, BUSY, 32'h0, "ill_busy1");
    step(0, 1'b1, 1'b0, 32'h100, 32'h0, ACCESS, 32'hCAFEF00D, "ill_acc");
    step(0, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0, "ill_rehold");
    step(0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "ill_idle");

    // Write abandoned in its ACCESS cycle.
    step(0, 1'b0, 1'b1, 32'h100, 32'h55AA55AA, FREE, 32'h0, "drop_c0");
    step(0, 1'b0, 1'b1, 32'h100, 32'h55AA55AA, BUSY, 32'h0, "drop_c1");
    step(0, 1'b0, 1'b1, 32'h100, 32'h55AA55AA, BUSY, 32'h0, "drop_c2");
    step(0, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h0, "drop_acc");
    step(0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "drop_free");
    xact(1'b1, 1'b0, 32'h100, 32'h0, 32'hCAFEF00D, "drop_rd");

    // Zero latency: each address held two cycles so its write commits.
    for (int i = 0; i < 4; i++) begin
      step(1, 1'b0, 1'b1, word_t'(i * 4), wv[i], (i == 0) ? FREE : ACCESS, 32'h0,
           $sformatf("z_wr%0d_a", i));
      step(1, 1'b0, 1'b1, word_t'(i * 4), wv[i], ACCESS, 32'h0, $sformatf("z_wr%0d_b", i));
    end
    step(1, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h0, "z_wr_tail");
    step(1, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "z_wr_idle");

    // Zero latency streaming reads: ACCESS every cycle.
    for (int i = 0; i < 4; i++) begin
      step(1, 1'b1, 1'b0, word_t'(i * 4), 32'h0, (i == 0) ? FREE : ACCESS,
           (i == 0) ? 32'h0 : wv[i-1], $sformatf("z_rd%0d", i));
    end
    step(1, 1'b1, 1'b0, 32'hC, 32'h0, ACCESS, wv[3], "z_rd_hold");
    step(1, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, wv[3], "z_rd_tail");
    step(1, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "z_rd_idle");

    @(negedge CLK);
    #1;
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
